dead_pix_loader: RTL and testbench
==================================

# dead_pix_loader

Sequencer that loads the dead-pixel table into the dead-pixel compare block at start-up or on request. It fetches a count word and up to MAX_DEAD coordinate words from the calibration EEPROM through a req/ack read port, validates each entry, and drives the compare block's `WR`/`Number`/`x_in`/`y_in` write port. It then overwrites every unused slot with a sentinel so stale entries never match. It sits between the EEPROM reader and the dead-pixel compare block.

## Interface
- MAX_DEAD, 24: table slots in the compare block (Number range 0..MAX_DEAD-1).
- EE_BASE, 10'h3C0: EEPROM address of the count word; entry i is at EE_BASE+1+i.
- X_MAX, 79: largest legal x coordinate.
- Y_MAX, 59: largest legal y coordinate.
- TIMEOUT, 255: cycles to wait for `ee_ack` before aborting.
- SENT_X, 7'd127: sentinel x written to unused slots; sentinel y is 0.
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a load. Ignored while busy.
- ee_req  out  1  EEPROM read request.
- ee_addr  out  10  EEPROM word address; stable while `ee_req`=1.
- ee_ack  in  1  read complete; `ee_data` is valid in the same cycle.
- ee_data  in  16  EEPROM word.
- WR  out  1  table write strobe to the compare block.
- Number  out  5  slot index for the write.
- x_in  out  7  x coordinate for the write.
- y_in  out  6  y coordinate for the write.
- busy  out  1  high from the cycle after `start` until `done`.
- done  out  1  one-cycle pulse when the load completes.
- valid_cnt  out  5  number of valid entries written in the last load.
- err  out  1  sticky error flag; cleared by the next accepted `start`.

## Operation
- **Reset values:** every output is 0; state is IDLE. Reset takes effect immediately, including mid-load. The compare block's table is not reset; a fresh `start` must be issued to rewrite it.
- **Count word:** `ee_data[4:0]` is N; other bits are ignored. If N>MAX_DEAD, use N=MAX_DEAD and set `err`.
- **Entry word:** x=`ee_data[6:0]`, y=`ee_data[12:7]`, `[15:13]` reserved. An entry is invalid if x>X_MAX or y>Y_MAX.
  - Invalid entry: set `err`, issue no write, do not consume a slot.
  - Invalid entries still count toward N reads.
- **States:**
  - IDLE: on `start`, go to RD_CNT; clear `err` and `valid_cnt`; set slot=0, i=0.
  - RD_CNT: `ee_req`=1, `ee_addr`=EE_BASE. On `ee_ack`, capture N and drop `ee_req`. Go to RD_ENT if N>0, else to FILL.
  - RD_ENT: `ee_req`=1, `ee_addr`=EE_BASE+1+i. On `ee_ack`, capture the word and increment i. Go to WRITE if the entry is valid, else to NEXT.
  - WRITE: `WR`=1, `Number`=slot, x/y from the entry; slot and `valid_cnt` increment. Go to NEXT.
  - NEXT: go to RD_ENT if i<N and slot<MAX_DEAD, else to FILL.
  - FILL: one write per cycle with `WR`=1, `Number`=slot, x=SENT_X, y=0, slot++, until slot=MAX_DEAD. Then go to DONE. If slot=MAX_DEAD on entry, pass straight to DONE.
  - DONE: `done`=1 for one cycle, `busy`=0, return to IDLE.
- **Timeout:** a wait counter clears on each new request. If it reaches TIMEOUT with no `ee_ack`:
  - drop `ee_req`, set `err`, go to FILL;
  - any later `ee_ack` is ignored.
- **Handshake rules:**
  - `ee_ack` while `ee_req`=0 is ignored.
  - `ee_req` deasserts in the cycle after the ack cycle.
  - At least one idle cycle separates consecutive requests.
- **Held outputs:** `Number`, `x_in` and `y_in` hold their last value when `WR`=0. `WR` is never high outside WRITE and FILL.

## Timing
- `start` sampled at edge 0 → `busy`=1 and `ee_req`=1 from edge 1.
- `ee_ack` at edge k → `ee_req`=0 at k+1.
- Next request at k+2 (NEXT/RD_ENT path). A valid entry's `WR` pulse is at k+1, followed by one NEXT cycle.
- N=0 with immediate ack: `start`@0, ack@1, FILL writes @2..25, `done`@26.
- `done` and `busy` fall in the same cycle. A `start` arriving in the DONE cycle is ignored.

## Test plan
- **Two valid entries:** N=2, words 0x0185 (x=5,y=3) and 0x1DCF (x=79,y=59), ack one cycle after each req → writes slot0=(5,3), slot1=(79,59), slots 2..23=(127,0); 24 `WR` pulses total; `valid_cnt`=2; `err`=0; one `done`.
- **Count overflow:** N=30 → exactly 24 entry reads, last `ee_addr`=0x3D8; `err`=1; `valid_cnt`=24; no FILL writes.
- **Invalid entry:** N=3, entry1 x=80 → slot0=entry0, slot1=entry2, slots 2..23 sentinel; `err`=1; `valid_cnt`=2.
- **Timeout:** entry1 ack withheld → `ee_req` drops 255 cycles after that request; `err`=1; slots 1..23 sentinel; `done` pulses; a late ack has no effect.
- **Reset during FILL:** `rst_n`=0 → `WR`, `busy`, `ee_req` are 0 immediately. After release, `start` performs a full clean load with 24 writes.
- **Ignored starts:** `start` repeated while busy → no restart, no extra writes. N=0 → 24 sentinel writes; `valid_cnt`=0.

Source files
------------

// File: rtl/dead_pix_loader_if.sv
// Bus bundle between the dead-pixel loader, the calibration EEPROM reader and the compare-block table.
// Carries the req/ack EEPROM read port and the WR/Number/x_in/y_in table write port.
// master = loader side; slave = EEPROM reader plus compare block side.
interface dead_pix_loader_if;
  logic        ee_req;
  logic [9:0]  ee_addr;
  logic        ee_ack;
  logic [15:0] ee_data;
  logic        WR;
  logic [4:0]  Number;
  logic [6:0]  x_in;
  logic [5:0]  y_in;

  modport master (
    output ee_req, ee_addr, WR, Number, x_in, y_in,
    input  ee_ack, ee_data
  );

  modport slave (
    input  ee_req, ee_addr, WR, Number, x_in, y_in,
    output ee_ack, ee_data
  );
endinterface

// File: rtl/dead_pix_loader.sv
// Loads the dead-pixel table from EEPROM into the compare block, then fills unused slots with a sentinel.
// Latency: one EEPROM request per entry, one write cycle per valid entry, one write per unused slot.
// Backpressure: waits on ee_ack up to TIMEOUT cycles per request, then abandons the read and fills.
module dead_pix_loader #(
  parameter int         MAX_DEAD = 24,
  parameter logic [9:0] EE_BASE  = 10'h3C0,
  parameter int         X_MAX    = 79,
  parameter int         Y_MAX    = 59,
  parameter int         TIMEOUT  = 255,
  parameter logic [6:0] SENT_X   = 7'd127
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  dead_pix_loader_if.master  bus,
  output logic               busy,
  output logic               done,
  output logic [4:0]         valid_cnt,
  output logic               err
);

  localparam logic [4:0] MAX_SLOT = 5'(MAX_DEAD);
  localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, RD_CNT, RD_ENT, WRITE, NEXT, FILL, DONE} state_t;

  state_t     state_q, state_d;
  logic [4:0] slot_q, i_q, n_q;
  logic [7:0] wait_q;
  logic [6:0] ent_x, x_h;
  logic [5:0] ent_y, y_h;
  logic [4:0] num_h;
  logic       wr;
  logic       ack_ok;
  logic       timed_out;
  logic       ent_ok;
  logic [4:0] cnt_raw;

  // Reserved entry bits are deliberately ignored.
  logic unused_rsvd;
  assign unused_rsvd = ^bus.ee_data[15:13];

  // An ack only counts while a request is outstanding.
  assign ack_ok    = bus.ee_req && bus.ee_ack;
  assign timed_out = bus.ee_req && !bus.ee_ack && (wait_q == TO_LAST);
  assign ent_ok    = (bus.ee_data[6:0] <= 7'(X_MAX)) && (bus.ee_data[12:7] <= 6'(Y_MAX));
  assign cnt_raw   = bus.ee_data[4:0];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and write-strobe decode.
  always_comb begin
    state_d = state_q;
    wr      = 1'b0;
    case (state_q)
      IDLE:   if (start) state_d = RD_CNT;
      // A non-zero count goes through NEXT so the request line idles one cycle between reads.
      RD_CNT: if (ack_ok) state_d = (cnt_raw != 5'd0) ? NEXT : FILL;
              else if (timed_out) state_d = FILL;
      RD_ENT: if (ack_ok) state_d = ent_ok ? WRITE : NEXT;
              else if (timed_out) state_d = FILL;
      WRITE: begin
        wr      = 1'b1;
        state_d = NEXT;
      end
      NEXT:   state_d = ((i_q < n_q) && (slot_q < MAX_SLOT)) ? RD_ENT : FILL;
      FILL: begin
        wr = (slot_q < MAX_SLOT);
        if (slot_q >= MAX_SLOT - 5'd1) state_d = DONE;
      end
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: counters, captured words, sticky error and held write-port values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q    <= '0;
      i_q       <= '0;
      n_q       <= '0;
      wait_q    <= '0;
      ent_x     <= '0;
      ent_y     <= '0;
      x_h       <= '0;
      y_h       <= '0;
      num_h     <= '0;
      valid_cnt <= '0;
      err       <= 1'b0;
    end else begin
      // The wait counter runs only while a request is outstanding, so every new request starts at zero.
      if (bus.ee_req) wait_q <= wait_q + 8'd1;
      else            wait_q <= '0;
      if (timed_out) err <= 1'b1;
      case (state_q)
        IDLE: if (start) begin
          err       <= 1'b0;
          valid_cnt <= '0;
          slot_q    <= '0;
          i_q       <= '0;
          n_q       <= '0;
        end
        RD_CNT: if (ack_ok) begin
          n_q <= (cnt_raw > MAX_SLOT) ? MAX_SLOT : cnt_raw;
          if (cnt_raw > MAX_SLOT) err <= 1'b1;
        end
        RD_ENT: if (ack_ok) begin
          i_q   <= i_q + 5'd1;
          ent_x <= bus.ee_data[6:0];
          ent_y <= bus.ee_data[12:7];
          if (!ent_ok) err <= 1'b1;
        end
        WRITE: begin
          slot_q    <= slot_q + 5'd1;
          valid_cnt <= valid_cnt + 5'd1;
          num_h     <= slot_q;
          x_h       <= ent_x;
          y_h       <= ent_y;
        end
        FILL: if (wr) begin
          slot_q <= slot_q + 5'd1;
          num_h  <= slot_q;
          x_h    <= SENT_X;
          y_h    <= 6'd0;
        end
        default: ;
      endcase
    end
  end

  assign bus.ee_req  = (state_q == RD_CNT) || (state_q == RD_ENT);
  assign bus.ee_addr = (state_q == RD_ENT) ? (EE_BASE + 10'd1 + {5'd0, i_q}) : EE_BASE;
  assign bus.WR      = wr;
  // Outside a write cycle the port shows the last written values.
  assign bus.Number  = wr ? slot_q : num_h;
  assign bus.x_in    = (state_q == WRITE) ? ent_x : (wr ? SENT_X : x_h);
  assign bus.y_in    = (state_q == WRITE) ? ent_y : (wr ? 6'd0 : y_h);
  assign busy        = (state_q != IDLE) && (state_q != DONE);
  assign done        = (state_q == DONE);

endmodule

// File: tb/tb_dead_pix_loader.sv
// Bench for dead_pix_loader: EEPROM responder, table-write monitor and a slot-level reference model.
// Directed scenarios followed by randomized loads.
// Responder acks after a programmable or random delay, or withholds one ack to force a timeout.
module tb_dead_pix_loader;
  localparam logic [9:0] BASE = 10'h3C0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy, done, err;
  logic [4:0] valid_cnt;

  dead_pix_loader_if bus();

  dead_pix_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(bus),
    .busy(busy), .done(done), .valid_cnt(valid_cnt), .err(err)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [0:1023];
  logic [12:0] tbl [0:23];
  logic [12:0] exp_tbl [0:23];
  int exp_valid, exp_req;
  logic exp_err;

  int checks = 0, passes = 0;
  int fixed_delay = 0, withhold_req = -1, req_idx = 0;
  int wr_cnt, done_cnt, req_cnt, gap_err, addr_chg, hold_err, bad_num, cur_len, last_len;
  logic [9:0] last_addr;
  logic prev_req = 0, prev_ack_req = 0, in_req = 0, served = 0, hold = 0;
  logic [17:0] prev_out = '0;
  int wait_n = 0, late_ack_due = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Monitor then responder, both on the falling edge so they never race each other.
  initial begin
    bus.ee_ack = 1'b0;
    bus.ee_data = '0;
    forever begin
      @(negedge clk);
      if (bus.WR) begin
        if (bus.Number < 5'd24) tbl[bus.Number] = {bus.x_in, bus.y_in};
        else bad_num++;
        wr_cnt++;
      end else if ({bus.Number, bus.x_in, bus.y_in} != prev_out) hold_err++;
      prev_out = {bus.Number, bus.x_in, bus.y_in};
      if (done) done_cnt++;
      if (prev_ack_req && bus.ee_req) gap_err++;
      prev_ack_req = bus.ee_ack && bus.ee_req;
      if (bus.ee_req) begin
        if (!prev_req) begin req_cnt++; cur_len = 0; end
        else if (bus.ee_addr != last_addr) addr_chg++;
        cur_len++;
        last_addr = bus.ee_addr;
      end else if (prev_req) last_len = cur_len;
      prev_req = bus.ee_req;

      bus.ee_ack = 1'b0;
      if (late_ack_due > 0) begin
        late_ack_due--;
        if (late_ack_due == 0) begin bus.ee_ack = 1'b1; bus.ee_data = 16'h0185; end
      end
      if (bus.ee_req) begin
        if (!in_req) begin
          in_req = 1; served = 0;
          wait_n = (fixed_delay >= 0) ? fixed_delay : $urandom_range(0, 3);
          hold = (req_idx == withhold_req);
          req_idx++;
        end
        if (!served && !hold) begin
          if (wait_n == 0) begin bus.ee_ack = 1'b1; bus.ee_data = mem[bus.ee_addr]; served = 1; end
          else wait_n--;
        end
      end else begin
        if (in_req && !served) late_ack_due = 3;
        in_req = 0;
      end
    end
  end

  // Expected table from the EEPROM image: valid entries packed from slot 0, sentinels after.
  task automatic model(input int wh);
    int n, slot;
    logic [15:0] w;
    n = int'(mem[BASE][4:0]);
    exp_err = 0;
    if (n > 24) begin n = 24; exp_err = 1; end
    exp_req = 1;
    slot = 0;
    if (wh == 0) begin exp_err = 1; n = 0; end
    for (int i = 0; i < n; i++) begin
      exp_req++;
      if (wh == i + 1) begin exp_err = 1; break; end
      w = mem[BASE + 10'd1 + 10'(i)];
      if (w[6:0] <= 7'd79 && w[12:7] <= 6'd59) begin
        exp_tbl[slot] = {w[6:0], w[12:7]};
        slot++;
      end else exp_err = 1;
    end
    exp_valid = slot;
    for (int s = slot; s < 24; s++) exp_tbl[s] = {7'd127, 6'd0};
  endtask

  task automatic gen_entry(output logic [15:0] w);
    logic [31:0] r;
    logic [6:0] x;
    logic [5:0] y;
    r = $urandom();
    x = 7'($urandom_range(0, 79));
    y = 6'($urandom_range(0, 59));
    if ($urandom_range(0, 3) == 0) begin
      if (r[4]) x = 7'($urandom_range(80, 127));
      else      y = 6'($urandom_range(60, 63));
    end
    w = {r[2:0], y, x};
  endtask

  task automatic run_load(input string nm, input int wh, input bit timing, input bit extra);
    int t, first_wr;
    bit got;
    model(wh);
    step();
    wr_cnt = 0; done_cnt = 0; req_cnt = 0; gap_err = 0; addr_chg = 0;
    hold_err = 0; bad_num = 0; last_len = 0;
    for (int s = 0; s < 24; s++) tbl[s] = '0;
    withhold_req = wh;
    req_idx = 0;
    start = 1'b1;
    t = 0; got = 0; first_wr = 0;
    while (t < 2000 && !got) begin
      step();
      t++;
      if (bus.WR && first_wr == 0) first_wr = t;
      if (t == 1) begin
        start = 1'b0;
        chk({nm, "_busy_rise"}, busy, 1);
        chk({nm, "_req_rise"}, bus.ee_req, 1);
        chk({nm, "_err_clr"}, err, 0);
      end
      if (extra && t == 5) start = 1'b1;
      if (extra && t == 6) start = 1'b0;
      if (done) begin
        got = 1;
        chk({nm, "_busy_at_done"}, busy, 0);
        if (timing) begin
          chk({nm, "_done_cycle"}, t, 26);
          chk({nm, "_first_wr"}, first_wr, 2);
        end
        if (extra) start = 1'b1;
      end
    end
    chk({nm, "_done_seen"}, got, 1);
    step();
    start = 1'b0;
    repeat (30) step();
    chk({nm, "_idle_busy"}, busy, 0);
    chk({nm, "_done_cnt"}, done_cnt, 1);
    chk({nm, "_wr_cnt"}, wr_cnt, 24);
    chk({nm, "_valid_cnt"}, valid_cnt, exp_valid);
    chk({nm, "_err"}, err, exp_err);
    chk({nm, "_reads"}, req_cnt, exp_req);
    chk({nm, "_last_addr"}, last_addr, BASE + 10'(exp_req - 1));
    chk({nm, "_handshake"}, gap_err + addr_chg + bad_num, 0);
    chk({nm, "_hold"}, hold_err, 0);
    if (wh >= 0) chk({nm, "_req_len"}, last_len, 255);
    for (int s = 0; s < 24; s++) chk($sformatf("%s_slot%0d", nm, s), tbl[s], exp_tbl[s]);
  endtask

  initial begin
    logic [15:0] w;
    logic [31:0] r;
    int n, wh;
    for (int a = 0; a < 1024; a++) mem[a] = 16'hFFFF;

    // Reset values
    #2;
    chk("rst_req", bus.ee_req, 0);
    chk("rst_wr", bus.WR, 0);
    chk("rst_port", {bus.Number, bus.x_in, bus.y_in}, 0);
    chk("rst_status", {busy, done, err, valid_cnt}, 0);
    step();
    rst_n = 1'b1;

    // Two valid entries, ack one cycle after each request
    fixed_delay = 1;
    mem[BASE] = 16'd2; mem[BASE + 1] = 16'h0185; mem[BASE + 2] = 16'h1DCF;
    run_load("two", -1, 0, 0);

    // Count overflow
    mem[BASE] = 16'd30;
    for (int i = 1; i <= 31; i++) mem[BASE + 10'(i)] = {3'b0, 6'(i % 60), 7'(i)};
    run_load("ovf", -1, 0, 0);

    // Invalid middle entry
    mem[BASE] = 16'd3; mem[BASE + 1] = 16'h0185; mem[BASE + 2] = 16'h0050; mem[BASE + 3] = 16'h0A0A;
    run_load("inv", -1, 0, 0);

    // Timeout on entry 1, followed by a late ack
    fixed_delay = -1;
    mem[BASE] = 16'd4;
    run_load("tmo", 2, 0, 0);

    // N=0 with immediate ack, exact timing, repeated starts
    fixed_delay = 0;
    mem[BASE] = 16'hFFE0;
    run_load("zero", -1, 1, 1);

    // Reset in the middle of FILL
    step(); start = 1'b1; step(); start = 1'b0;
    repeat (8) step();
    chk("pre_rst_wr", bus.WR, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_wr", bus.WR, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_req", bus.ee_req, 0);
    step(); step();
    rst_n = 1'b1;
    fixed_delay = -1;
    mem[BASE] = 16'd5;
    for (int i = 1; i <= 5; i++) begin gen_entry(w); mem[BASE + 10'(i)] = w; end
    run_load("after_rst", -1, 0, 0);

    // Randomized loads
    for (int k = 0; k < 10; k++) begin
      r = $urandom();
      n = $urandom_range(0, 31);
      mem[BASE] = {r[15:5], 5'(n)};
      for (int i = 1; i <= 31; i++) begin gen_entry(w); mem[BASE + 10'(i)] = w; end
      wh = -1;
      if ($urandom_range(0, 5) == 0) wh = $urandom_range(0, (n > 24) ? 24 : n);
      run_load($sformatf("rnd%0d", k), wh, 0, 0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
